// File: rtl/div_pkg.sv
// Shared definitions for the divide reservation station.
// Op encodings and per-entry field widths.
package div_pkg;

  localparam int DIV_OP_W = 2;

  typedef logic [DIV_OP_W-1:0] div_op_t;

  localparam div_op_t DIV_OP_DIV  = 2'b00;
  localparam div_op_t DIV_OP_DIVU = 2'b01;
  localparam div_op_t DIV_OP_REM  = 2'b10;
  localparam div_op_t DIV_OP_REMU = 2'b11;

  localparam int RS_DATA_W = 32;
  localparam int RS_TAG_W  = 6;

endpackage

// File: rtl/div_age_picker.sv
// Age matrix for the divide RS plus one-hot oldest-ready select.
// older[i][j] set means entry i was allocated before entry j.
module div_age_picker #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] ready,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] older [DEPTH];
  logic [DEPTH-1:0] blk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        older[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (alloc_oh[i])
            older[i][j] <= 1'b0;
          else if (alloc_oh[j])
            older[i][j] <= 1'b1;
        end
      end
    end
  end

  // Stale bits of freed entries are masked by ready.
  always_comb begin
    blk = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && older[j][i])
          blk[i] = 1'b1;
    grant = ready & ~blk;
  end

endmodule

// File: rtl/div_reservation_station.sv
// Reservation station in front of the multicycle divider.
// Buffers ops, snoops the CDB, issues oldest ready op.
module div_reservation_station
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = RS_DATA_W,
  parameter int TAG_WIDTH  = RS_TAG_W,
  parameter int DEPTH      = 4,
  localparam int CW        = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  div_op_t               alloc_op,
  input  logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  alloc_s1_rdy,
  input  logic [TAG_WIDTH-1:0]  alloc_s1_tag,
  input  logic [DATA_WIDTH-1:0] alloc_s1_val,
  input  logic                  alloc_s2_rdy,
  input  logic [TAG_WIDTH-1:0]  alloc_s2_tag,
  input  logic [DATA_WIDTH-1:0] alloc_s2_val,
  input  logic                  cdb_valid,
  input  logic [TAG_WIDTH-1:0]  cdb_tag,
  input  logic [DATA_WIDTH-1:0] cdb_data,
  input  logic                  div_busy,
  input  logic                  div_done,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_a,
  output logic [DATA_WIDTH-1:0] div_b,
  output div_op_t               div_op,
  output logic [TAG_WIDTH-1:0]  div_tag,
  output logic                  div_inflight,
  output logic [CW-1:0]         rs_count
);

  logic [DEPTH-1:0]      valid;
  logic [DEPTH-1:0]      s1_rdy;
  logic [DEPTH-1:0]      s2_rdy;
  div_op_t               op_q   [DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q  [DEPTH];
  logic [TAG_WIDTH-1:0]  s1_tag [DEPTH];
  logic [TAG_WIDTH-1:0]  s2_tag [DEPTH];
  logic [DATA_WIDTH-1:0] s1_val [DEPTH];
  logic [DATA_WIDTH-1:0] s2_val [DEPTH];

  logic                  alloc_fire;
  logic [DEPTH-1:0]      alloc_oh;
  logic                  found;
  logic [DEPTH-1:0]      ready;
  logic [DEPTH-1:0]      grant;
  logic [DEPTH-1:0]      iss_oh;
  logic                  done_ok;
  logic                  issue;
  logic                  hit1;
  logic                  hit2;
  div_op_t               sel_op;
  logic [TAG_WIDTH-1:0]  sel_tag;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;

  assign alloc_ready = ~&valid;
  assign alloc_fire  = alloc_valid & alloc_ready & ~flush;
  assign ready       = valid & s1_rdy & s2_rdy;
  assign done_ok     = div_done & ~div_start;
  assign issue       = |ready & ~flush & ~div_busy
                     & (~div_inflight | done_ok);
  assign iss_oh      = grant & {DEPTH{issue}};

  assign hit1 = cdb_valid & ~alloc_s1_rdy
              & (cdb_tag == alloc_s1_tag);
  assign hit2 = cdb_valid & ~alloc_s2_rdy
              & (cdb_tag == alloc_s2_tag);

  always_comb begin
    alloc_oh = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !found) begin
        alloc_oh[i] = alloc_fire;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    sel_op  = '0;
    sel_tag = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_op  = sel_op  | op_q[i];
        sel_tag = sel_tag | tag_q[i];
        sel_a   = sel_a   | s1_val[i];
        sel_b   = sel_b   | s2_val[i];
      end
    end
  end

  div_age_picker #(
    .DEPTH(DEPTH)
  ) u_age (
    .clk     (clk),
    .rst_n   (rst_n),
    .alloc_oh(alloc_oh),
    .ready   (ready),
    .grant   (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= '0;
      s1_rdy <= '0;
      s2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        tag_q[i]  <= '0;
        s1_tag[i] <= '0;
        s2_tag[i] <= '0;
        s1_val[i] <= '0;
        s2_val[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc_oh[i]) begin
          valid[i]  <= 1'b1;
          op_q[i]   <= alloc_op;
          tag_q[i]  <= alloc_tag;
          s1_tag[i] <= alloc_s1_tag;
          s2_tag[i] <= alloc_s2_tag;
          s1_rdy[i] <= alloc_s1_rdy | hit1;
          s2_rdy[i] <= alloc_s2_rdy | hit2;
          s1_val[i] <= hit1 ? cdb_data : alloc_s1_val;
          s2_val[i] <= hit2 ? cdb_data : alloc_s2_val;
        end else begin
          if (iss_oh[i])
            valid[i] <= 1'b0;
          if (valid[i] && !s1_rdy[i] && cdb_valid
              && cdb_tag == s1_tag[i]) begin
            s1_rdy[i] <= 1'b1;
            s1_val[i] <= cdb_data;
          end
          if (valid[i] && !s2_rdy[i] && cdb_valid
              && cdb_tag == s2_tag[i]) begin
            s2_rdy[i] <= 1'b1;
            s2_val[i] <= cdb_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_start    <= 1'b0;
      div_a        <= '0;
      div_b        <= '0;
      div_op       <= '0;
      div_tag      <= '0;
      div_inflight <= 1'b0;
      rs_count     <= '0;
    end else begin
      div_start <= issue;
      if (issue) begin
        div_a   <= sel_a;
        div_b   <= sel_b;
        div_op  <= sel_op;
        div_tag <= sel_tag;
      end
      // A new issue on the done edge keeps inflight high.
      if (flush)
        div_inflight <= 1'b0;
      else if (issue)
        div_inflight <= 1'b1;
      else if (done_ok)
        div_inflight <= 1'b0;
      if (flush)
        rs_count <= '0;
      else if (alloc_fire && !issue)
        rs_count <= rs_count + CW'(1);
      else if (issue && !alloc_fire)
        rs_count <= rs_count - CW'(1);
    end
  end

endmodule

// File: tb/tb_div_reservation_station.sv
// Directed bench for div_reservation_station.
// Sequence-number model checked every cycle plus literal pins.
module tb_div_reservation_station;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int DEPTH = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic alloc_valid = 1'b0;
  logic alloc_ready;
  logic [1:0] alloc_op = '0;
  logic [TW-1:0] alloc_tag = '0;
  logic alloc_s1_rdy = 1'b0;
  logic [TW-1:0] alloc_s1_tag = '0;
  logic [DW-1:0] alloc_s1_val = '0;
  logic alloc_s2_rdy = 1'b0;
  logic [TW-1:0] alloc_s2_tag = '0;
  logic [DW-1:0] alloc_s2_val = '0;
  logic cdb_valid = 1'b0;
  logic [TW-1:0] cdb_tag = '0;
  logic [DW-1:0] cdb_data = '0;
  logic div_busy = 1'b0;
  logic div_done = 1'b1;
  logic div_start;
  logic [DW-1:0] div_a;
  logic [DW-1:0] div_b;
  logic [1:0] div_op;
  logic [TW-1:0] div_tag;
  logic div_inflight;
  logic [CW-1:0] rs_count;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  div_reservation_station #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_op(alloc_op), .alloc_tag(alloc_tag),
    .alloc_s1_rdy(alloc_s1_rdy), .alloc_s1_tag(alloc_s1_tag),
    .alloc_s1_val(alloc_s1_val),
    .alloc_s2_rdy(alloc_s2_rdy), .alloc_s2_tag(alloc_s2_tag),
    .alloc_s2_val(alloc_s2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .div_busy(div_busy), .div_done(div_done),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_op(div_op), .div_tag(div_tag),
    .div_inflight(div_inflight), .rs_count(rs_count)
  );

  always #5 clk = ~clk;

  // Model: entries with allocation sequence numbers.
  bit            m_v  [DEPTH];
  bit            m_r1 [DEPTH];
  bit            m_r2 [DEPTH];
  logic [1:0]    m_op [DEPTH];
  logic [TW-1:0] m_tg [DEPTH];
  logic [TW-1:0] m_t1 [DEPTH];
  logic [TW-1:0] m_t2 [DEPTH];
  logic [DW-1:0] m_v1 [DEPTH];
  logic [DW-1:0] m_v2 [DEPTH];
  int            m_age[DEPTH];
  int            seq;
  bit            e_start, e_infl;
  logic [DW-1:0] e_a, e_b;
  logic [1:0]    e_op;
  logic [TW-1:0] e_tag;
  int            e_cnt;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit m_full();
    bit f = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      if (!m_v[i]) f = 1'b0;
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_v[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0;
    end
    seq = 0; e_start = 0; e_infl = 0;
    e_a = '0; e_b = '0; e_op = '0; e_tag = '0; e_cnt = 0;
  endtask

  task automatic model_step();
    int iss, al;
    bit do_iss, done_ok;
    done_ok = div_done && !e_start;
    iss = -1;
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i] && m_r1[i] && m_r2[i]
          && (iss < 0 || m_age[i] < m_age[iss]))
        iss = i;
    do_iss = (iss >= 0) && !flush && !div_busy
             && (!e_infl || done_ok);
    al = -1;
    for (int i = 0; i < DEPTH; i++)
      if (!m_v[i] && al < 0) al = i;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
      e_start = 0; e_infl = 0; e_cnt = 0;
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_v[i] && cdb_valid) begin
        if (!m_r1[i] && m_t1[i] == cdb_tag) begin
          m_r1[i] = 1'b1; m_v1[i] = cdb_data;
        end
        if (!m_r2[i] && m_t2[i] == cdb_tag) begin
          m_r2[i] = 1'b1; m_v2[i] = cdb_data;
        end
      end
    end
    if (do_iss) begin
      e_a = m_v1[iss]; e_b = m_v2[iss];
      e_op = m_op[iss]; e_tag = m_tg[iss];
      m_v[iss] = 1'b0;
    end
    e_infl = do_iss ? 1'b1 : (done_ok ? 1'b0 : e_infl);
    e_start = do_iss;
    if (alloc_valid && al >= 0) begin
      m_v[al] = 1'b1; m_op[al] = alloc_op; m_tg[al] = alloc_tag;
      m_t1[al] = alloc_s1_tag; m_t2[al] = alloc_s2_tag;
      m_r1[al] = alloc_s1_rdy
                 || (cdb_valid && cdb_tag == alloc_s1_tag);
      m_r2[al] = alloc_s2_rdy
                 || (cdb_valid && cdb_tag == alloc_s2_tag);
      m_v1[al] = (!alloc_s1_rdy && cdb_valid
                  && cdb_tag == alloc_s1_tag) ? cdb_data : alloc_s1_val;
      m_v2[al] = (!alloc_s2_rdy && cdb_valid
                  && cdb_tag == alloc_s2_tag) ? cdb_data : alloc_s2_val;
      m_age[al] = seq;
      seq++;
    end
    e_cnt = 0;
    for (int i = 0; i < DEPTH; i++)
      if (m_v[i]) e_cnt++;
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("start",    64'(div_start),    64'(e_start));
      chk("inflight", 64'(div_inflight), 64'(e_infl));
      chk("a",        64'(div_a),        64'(e_a));
      chk("b",        64'(div_b),        64'(e_b));
      chk("op",       64'(div_op),       64'(e_op));
      chk("tag",      64'(div_tag),      64'(e_tag));
      chk("count",    64'(rs_count),     64'(e_cnt));
      chk("ready",    64'(alloc_ready),  64'(!m_full()));
    end
  end

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
    alloc_valid = 1'b0;
    cdb_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic alloc(input logic [1:0] op, input int tag,
                       input bit r1, input int t1, input int v1,
                       input bit r2, input int t2, input int v2);
    alloc_valid = 1'b1; alloc_op = op; alloc_tag = TW'(tag);
    alloc_s1_rdy = r1; alloc_s1_tag = TW'(t1); alloc_s1_val = DW'(v1);
    alloc_s2_rdy = r2; alloc_s2_tag = TW'(t2); alloc_s2_val = DW'(v2);
  endtask

  task automatic cdb(input int tag, input int data);
    cdb_valid = 1'b1; cdb_tag = TW'(tag); cdb_data = DW'(data);
  endtask

  task automatic busy(input bit b);
    div_busy = b;
    div_done = !b;
  endtask

  task automatic run_div();
    busy(1); tick(); tick();
    busy(0); tick();
  endtask

  task automatic lit(string nm, logic [63:0] act, logic [63:0] exp);
    chk(nm, act, exp);
  endtask

  initial begin
    model_reset();
    #12;
    lit("rst_start", 64'(div_start), 64'd0);
    lit("rst_ready", 64'(alloc_ready), 64'd1);
    lit("rst_count", 64'(rs_count), 64'd0);
    lit("rst_infl", 64'(div_inflight), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Ready op issues one cycle after alloc
    alloc(2'b00, 5, 1, 0, 100, 1, 0, 7); tick();
    lit("s1_count", 64'(rs_count), 64'd1);
    lit("s1_nostart", 64'(div_start), 64'd0);
    tick();
    lit("s1_start", 64'(div_start), 64'd1);
    lit("s1_a", 64'(div_a), 64'd100);
    lit("s1_b", 64'(div_b), 64'd7);
    lit("s1_tag", 64'(div_tag), 64'd5);
    lit("s1_infl", 64'(div_inflight), 64'd1);
    tick();
    lit("s1_done_ign", 64'(div_inflight), 64'd1);
    run_div();
    lit("s1_cleared", 64'(div_inflight), 64'd0);

    // CDB wakeup, then alloc-cycle bypass
    alloc(2'b01, 10, 0, 9, 0, 1, 0, 3); tick(); tick();
    lit("s2_wait", 64'(div_start), 64'd0);
    cdb(9, 42); tick();
    lit("s2_noissue_same", 64'(div_start), 64'd0);
    tick();
    lit("s2_start", 64'(div_start), 64'd1);
    lit("s2_a", 64'(div_a), 64'd42);
    run_div();
    alloc(2'b10, 11, 0, 12, 0, 1, 0, 4); cdb(12, 55); tick(); tick();
    lit("s2b_start", 64'(div_start), 64'd1);
    lit("s2b_a", 64'(div_a), 64'd55);
    lit("s2b_op", 64'(div_op), 64'd2);
    run_div();

    // Age ordering and back-to-back on done
    alloc(2'b00, 20, 0, 30, 0, 1, 0, 3); tick();
    alloc(2'b00, 21, 1, 0, 8, 1, 0, 2); tick();
    cdb(30, 9); tick();
    lit("s3_b_first", 64'(div_tag), 64'd21);
    busy(1); tick();
    lit("s3_hold", 64'(div_start), 64'd0);
    tick(); busy(0); tick();
    lit("s3_b2b_start", 64'(div_start), 64'd1);
    lit("s3_b2b_tag", 64'(div_tag), 64'd20);
    lit("s3_b2b_infl", 64'(div_inflight), 64'd1);
    busy(1);
    alloc(2'b11, 22, 1, 0, 50, 1, 0, 5); tick();
    alloc(2'b11, 23, 1, 0, 60, 1, 0, 6); tick();
    busy(0); tick();
    lit("s3_older", 64'(div_tag), 64'd22);
    busy(1); tick(); busy(0); tick();
    lit("s3_younger", 64'(div_tag), 64'd23);
    run_div();

    // Fill, full, free one slot
    busy(1);
    for (int k = 0; k < DEPTH; k++) begin
      alloc(2'b00, 40 + k, 1, 0, 200 + k, 1, 0, 1 + k); tick();
    end
    lit("s4_full_cnt", 64'(rs_count), 64'(DEPTH));
    lit("s4_full_rdy", 64'(alloc_ready), 64'd0);
    alloc(2'b00, 44, 1, 0, 1, 1, 0, 1); tick();
    lit("s4_drop", 64'(rs_count), 64'(DEPTH));
    busy(0); tick();
    lit("s4_issue_tag", 64'(div_tag), 64'd40);
    lit("s4_cnt", 64'(rs_count), 64'(DEPTH - 1));
    lit("s4_rdy", 64'(alloc_ready), 64'd1);
    busy(1);
    alloc(2'b01, 45, 1, 0, 9, 1, 0, 3); tick();
    lit("s4_refill", 64'(rs_count), 64'(DEPTH));

    // Flush with op in flight and entries waiting
    flush = 1'b1;
    alloc(2'b00, 46, 1, 0, 1, 1, 0, 1); tick();
    lit("s5_cnt", 64'(rs_count), 64'd0);
    lit("s5_infl", 64'(div_inflight), 64'd0);
    alloc(2'b00, 50, 1, 0, 77, 1, 0, 11); tick(); tick();
    lit("s5_blocked", 64'(div_start), 64'd0);
    busy(0); tick();
    lit("s5_tag", 64'(div_tag), 64'd50);
    lit("s5_a", 64'(div_a), 64'd77);

    // Async reset mid-divide
    busy(1);
    alloc(2'b10, 51, 1, 0, 3, 1, 0, 3); tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    lit("s6_start", 64'(div_start), 64'd0);
    lit("s6_infl", 64'(div_inflight), 64'd0);
    lit("s6_cnt", 64'(rs_count), 64'd0);
    lit("s6_rdy", 64'(alloc_ready), 64'd1);
    lit("s6_a", 64'(div_a), 64'd0);
    lit("s6_tag", 64'(div_tag), 64'd0);
    @(posedge clk); @(negedge clk); #1;
    rst_n = 1'b1;
    busy(0);
    alloc(2'b11, 60, 1, 0, 1000, 1, 0, 9); tick(); tick();
    lit("s6_rec_a", 64'(div_a), 64'd1000);
    lit("s6_rec_op", 64'(div_op), 64'd3);
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
